link_cable_peer: RTL and testbench
==================================

// Module: link_cable_peer
// PURPOSE
// - Behavioural model of the device at the far end of the DMG serial link cable: it shifts one byte
//   in and one byte out per transfer, the counterpart of the CPU serial port (SB/SC).
// - Sits in the top-level testbench/harness and connects to the DMG SCK, SIN and SOUT pins.
// - Slave mode: follows the DMG internal clock. Master mode: generates SCK so the DMG runs
//   on an external clock.
// - All logic runs on the fast simulation clock. SCK and the DMG SOUT pin are treated as
//   asynchronous inputs.
// PARAMETERS
// - HALF_PERIOD   64    clk cycles per SCK half-period when this peer is master (>=2)
// - TIMEOUT       4096  slave mode: clk cycles without an SCK edge mid-byte before the transfer aborts
// - IDLE_BYTE     8'hFF byte shifted out when no tx byte is pending (pulled-up line)
// PORTS
// - clk          in   1  simulation clock
// - reset_n      in   1  reset, asynchronous assert, active-low
// - master       in   1  1 = peer drives SCK; 0 = peer follows DMG SCK. Sampled only in IDLE.
// - tx_data      in   8  next byte to send
// - tx_valid     in   1  tx_data valid; a byte is accepted when tx_valid && tx_ready
// - tx_ready     out  1  1-entry holding register empty
// - rx_data      out  8  last received byte; held until the next completion
// - rx_valid     out  1  single-clk pulse when rx_data updates
// - busy         out  1  transfer in progress (state != IDLE)
// - sck_in       in   1  SCK pin as seen by the peer
// - sck_out      out  1  SCK value driven when master
// - sck_oe       out  1  1 = peer drives SCK (master and not IDLE)
// - sin_dmg      in   1  DMG SOUT pin (data into the peer)
// - sout_dmg     out  1  drives DMG SIN (data out of the peer); always shift_reg[7]
// BEHAVIOUR
// - Reset values:
//   - tx_ready=1, rx_data=0, rx_valid=0, busy=0, sck_out=1, sck_oe=0.
//   - shift_reg=IDLE_BYTE, so sout_dmg=1.
//   - bit_cnt=0, state=IDLE.
// - Synchronisers:
//   - sck_in and sin_dmg each pass through 2 flops.
//   - Edges are detected on the synchronised SCK against its previous value.
//   - Edge-to-action latency is 3 clk.
// - Holding register:
//   - Accepts a byte when tx_ready is 1.
//   - Loaded into shift_reg at transfer start. If empty at transfer start, IDLE_BYTE is loaded instead.
//   - Accept and load in the same clk: the new byte goes to the holding register; the load uses the old contents.
// - States: IDLE, S_XFER, M_LOW, M_HIGH.
// - IDLE -> S_XFER: master=0 and a falling SCK edge is seen. Prime shift_reg from the holding register.
// - IDLE -> M_LOW: master=1 and the holding register is full. Load shift_reg, set sck_oe=1, sck_out=0,
//   clear the half-period counter.
// - Sampling and shifting, both modes:
//   - Rising SCK: capture the sync'd sin_dmg into rx_bit and increment bit_cnt.
//   - Falling SCK with bit_cnt != 0: shift_reg <= {shift_reg[6:0], rx_bit}.
//   - MSB first.
//   - In master mode the edges are internal: M_LOW -> M_HIGH is a rise, M_HIGH -> M_LOW is a fall.
//   - Each master edge occurs after HALF_PERIOD clk.
// - Completion, on the 8th rising edge:
//   - rx_data <= {shift_reg[6:0], rx_bit} and rx_valid pulses the next clk.
//   - bit_cnt <= 0; go to IDLE, sck_oe=0.
//   - shift_reg reloads from the holding register or IDLE_BYTE.
// - Slave timeout:
//   - In S_XFER with bit_cnt in 1..7 and no SCK edge for TIMEOUT clk, return to IDLE.
//   - No rx_valid; bit_cnt=0; shift_reg=IDLE_BYTE; the holding register is not consumed again.
// - master changing mid-transfer: ignored until IDLE.
// - reset_n low mid-transfer: immediately restores all reset values; a partial byte is discarded.
// - Glitch: a SCK pulse shorter than 2 clk may be missed; not an error.
// STRUCTURE
// - link_pkg:
//   - typedef enum logic [1:0] link_state_t {IDLE, S_XFER, M_LOW, M_HIGH}
//   - localparam SERIAL_BITS=8
//   - localparam SCK_IDLE=1'b1
// - Sub-module sync2 (2-flop synchroniser, async active-low reset, parameterised reset value).
//   Instantiate twice: SCK resets to 1, sin_dmg resets to 1.
// - Half-period counter: $clog2(HALF_PERIOD) bits. Timeout counter: $clog2(TIMEOUT+1) bits,
//   saturating. bit_cnt: 4 bits.
// TESTING
// - Slave: load 8'hA5; DMG sends 8'h3C at 8 kHz -> rx_data=8'h3C with one rx_valid pulse;
//   sampled sout_dmg bits are 1,0,1,0,0,1,0,1.
// - Slave, empty tx: DMG clocks one byte -> sout_dmg=1 for all 8 bits; rx_valid pulses once.
// - Master, HALF_PERIOD=4: load 8'h81 with sin_dmg tied 0 -> 8 SCK periods of 8 clk; sck_oe drops
//   after the 8th rise; rx_data=8'h00.
// - Timeout: 3 SCK pulses then silence for TIMEOUT+10 clk -> busy falls, no rx_valid; a next full
//   byte 8'h5A is received correctly.
// - Reset mid-transfer after 5 bits -> all outputs at reset values within 1 clk; next transfer clean.
// - Back-to-back: hold tx_valid with 8'h11 then 8'h22 -> second accepted while first shifts; peer
//   sends 8'h11 then 8'h22 and no IDLE_BYTE in between.

Source files
------------

// File: rtl/link_cable_peer_pkg.sv
// Shared types and constants for the serial link cable peer model.
package link_pkg;

  typedef enum logic [1:0] {IDLE, S_XFER, M_LOW, M_HIGH} link_state_t;

  localparam int SERIAL_BITS = 8;
  localparam logic SCK_IDLE = 1'b1;

endpackage

// File: rtl/link_cable_peer_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/link_cable_peer.sv
// Far-end device of the DMG link cable: shifts one byte in and one out per transfer,
// either following the DMG clock (slave) or generating SCK itself (master).
module link_cable_peer
  import link_pkg::*;
#(
  parameter int         HALF_PERIOD = 64,
  parameter int         TIMEOUT     = 4096,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       master,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  input  logic       sck_in,
  output logic       sck_out,
  output logic       sck_oe,
  input  logic       sin_dmg,
  output logic       sout_dmg
);

  localparam int HP_W = $clog2(HALF_PERIOD);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [HP_W-1:0] HP_LAST  = HP_W'(HALF_PERIOD - 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);
  localparam logic [3:0]      LAST_BIT = 4'(SERIAL_BITS - 1);

  link_state_t state, state_next;

  logic            sck_sync, sin_sync, sck_prev;
  logic            sck_rise, sck_fall;
  logic [7:0]      shift_reg, hold_data, load_byte;
  logic            hold_full, rx_bit;
  logic [3:0]      bit_cnt;
  logic [HP_W-1:0] hp_cnt;
  logic [TO_W-1:0] tmo_cnt;
  logic            do_load, do_rise, do_fall, do_done, do_abort;
  logic            hp_clear, tmo_clear, accept;

  sync2 #(.RESET_VAL(SCK_IDLE)) u_sck_sync (
    .clk(clk), .reset_n(reset_n), .d(sck_in), .q(sck_sync)
  );

  sync2 #(.RESET_VAL(1'b1)) u_sin_sync (
    .clk(clk), .reset_n(reset_n), .d(sin_dmg), .q(sin_sync)
  );

  assign sck_rise  = sck_sync & ~sck_prev;
  assign sck_fall  = ~sck_sync & sck_prev;
  assign accept    = tx_valid & ~hold_full;
  assign load_byte = hold_full ? hold_data : IDLE_BYTE;

  assign tx_ready = ~hold_full;
  assign busy     = (state != IDLE);
  assign sck_oe   = (state == M_LOW) || (state == M_HIGH);
  assign sck_out  = (state == M_LOW) ? ~SCK_IDLE : SCK_IDLE;
  assign sout_dmg = shift_reg[7];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    do_load    = 1'b0;
    do_rise    = 1'b0;
    do_fall    = 1'b0;
    do_done    = 1'b0;
    do_abort   = 1'b0;
    hp_clear   = 1'b1;
    tmo_clear  = 1'b1;
    case (state)
      IDLE: begin
        if (master) begin
          if (hold_full) begin
            state_next = M_LOW;
            do_load    = 1'b1;
          end
        end else if (sck_fall) begin
          state_next = S_XFER;
          do_load    = 1'b1;
        end
      end
      S_XFER: begin
        if (sck_rise) begin
          do_rise = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            do_done    = 1'b1;
            state_next = IDLE;
          end
        end else if (sck_fall) begin
          do_fall = 1'b1;
        end else if (bit_cnt != 4'd0) begin
          // A DMG that stops clocking mid-byte must not wedge the peer forever.
          tmo_clear = 1'b0;
          if (tmo_cnt >= TO_LIMIT) begin
            do_abort   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      M_LOW: begin
        if (hp_cnt == HP_LAST) begin
          do_rise = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            do_done    = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = M_HIGH;
          end
        end else begin
          hp_clear = 1'b0;
        end
      end
      M_HIGH: begin
        if (hp_cnt == HP_LAST) begin
          do_fall    = 1'b1;
          state_next = M_LOW;
        end else begin
          hp_clear = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Completion only previews the next byte on sout; the holding register is consumed at transfer start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_prev  <= SCK_IDLE;
      shift_reg <= IDLE_BYTE;
      hold_data <= 8'h00;
      hold_full <= 1'b0;
      rx_bit    <= 1'b0;
      bit_cnt   <= 4'd0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      hp_cnt    <= '0;
      tmo_cnt   <= '0;
    end else begin
      sck_prev <= sck_sync;
      rx_valid <= 1'b0;
      if (do_load) begin
        shift_reg <= load_byte;
        hold_full <= 1'b0;
      end
      if (accept) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end
      if (do_rise) begin
        rx_bit  <= sin_sync;
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (do_fall && (bit_cnt != 4'd0)) shift_reg <= {shift_reg[6:0], rx_bit};
      if (do_done) begin
        rx_data   <= {shift_reg[6:0], sin_sync};
        rx_valid  <= 1'b1;
        bit_cnt   <= 4'd0;
        shift_reg <= load_byte;
      end
      if (do_abort) begin
        bit_cnt   <= 4'd0;
        shift_reg <= IDLE_BYTE;
      end
      if (hp_clear)       hp_cnt <= '0;
      else                hp_cnt <= hp_cnt + 1'b1;
      if (tmo_clear)      tmo_cnt <= '0;
      else if (tmo_cnt != TO_LIMIT) tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_link_cable_peer.sv
// Directed bench for link_cable_peer: a small DMG model drives SCK/SOUT and checks each scenario.
module tb_link_cable_peer;

  localparam int TIMEOUT = 4096;
  localparam int SCK_HALF = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       master = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       sck_in = 1'b1;
  logic       sck_out;
  logic       sck_oe;
  logic       sin_dmg = 1'b1;
  logic       sout_dmg;

  int total = 0;
  int bad = 0;
  int pulses = 0;

  link_cable_peer #(.HALF_PERIOD(4), .TIMEOUT(TIMEOUT), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .reset_n(reset_n), .master(master),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .sck_in(sck_in), .sck_out(sck_out), .sck_oe(sck_oe),
    .sin_dmg(sin_dmg), .sout_dmg(sout_dmg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rx_valid === 1'b1) pulses++;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offers a byte until the peer takes it; gives up after a bounded wait.
  task automatic load_tx(input logic [7:0] b);
    bit ok = 1'b0;
    tx_data  = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (tx_ready === 1'b1) ok = 1'b1;
      @(negedge clk);
      if (ok) break;
    end
    tx_valid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL load_tx: byte %h never accepted (tx_ready=%b, wanted 1)", b, tx_ready);
    end
  endtask

  // DMG as master: drives a bit on the falling edge, samples the peer just before rising.
  task automatic dmg_bits(input logic [7:0] send, input int nbits, output logic [7:0] seen);
    seen = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      sck_in  = 1'b0;
      sin_dmg = send[i];
      wait_clk(SCK_HALF);
      seen = {seen[6:0], sout_dmg};
      sck_in = 1'b1;
      wait_clk(SCK_HALF);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    wait_clk(3);
    total += 7;
    if (tx_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset tx_ready: got %b want 1", tx_ready); end
    if (rx_data !== 8'h00) begin bad++; $display("[TB] FAIL reset rx_data: got %h want 00", rx_data); end
    if (rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset rx_valid: got %b want 0", rx_valid); end
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset busy: got %b want 0", busy); end
    if (sck_out !== 1'b1) begin bad++; $display("[TB] FAIL reset sck_out: got %b want 1", sck_out); end
    if (sck_oe !== 1'b0) begin bad++; $display("[TB] FAIL reset sck_oe: got %b want 0", sck_oe); end
    if (sout_dmg !== 1'b1) begin bad++; $display("[TB] FAIL reset sout_dmg: got %b want 1", sout_dmg); end
    reset_n = 1'b1;
    wait_clk(3);
  endtask

  task automatic test_slave;
    logic [7:0] seen;
    int p0;
    load_tx(8'hA5);
    p0 = pulses;
    dmg_bits(8'h3C, 8, seen);
    total += 4;
    if (rx_data !== 8'h3C) begin bad++; $display("[TB] FAIL slave rx_data: got %h want 3c", rx_data); end
    if (pulses - p0 !== 1) begin bad++; $display("[TB] FAIL slave rx_valid count: got %0d want 1", pulses - p0); end
    if (seen !== 8'hA5) begin bad++; $display("[TB] FAIL slave sout bits: got %h want a5", seen); end
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL slave busy after: got %b want 0", busy); end
  endtask

  task automatic test_slave_empty;
    logic [7:0] seen;
    int p0;
    p0 = pulses;
    dmg_bits(8'h96, 8, seen);
    total += 3;
    if (seen !== 8'hFF) begin bad++; $display("[TB] FAIL empty sout bits: got %h want ff", seen); end
    if (rx_data !== 8'h96) begin bad++; $display("[TB] FAIL empty rx_data: got %h want 96", rx_data); end
    if (pulses - p0 !== 1) begin bad++; $display("[TB] FAIL empty rx_valid count: got %0d want 1", pulses - p0); end
  endtask

  task automatic test_master;
    logic [7:0] seen = 8'h00;
    logic prev_sck, prev_sout;
    bit saw_oe = 1'b0;
    int rises = 0, first = 0, last = 0, p0;
    master  = 1'b1;
    sin_dmg = 1'b0;
    wait_clk(4);
    p0 = pulses;
    load_tx(8'h81);
    prev_sck  = sck_out;
    prev_sout = sout_dmg;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sck_oe === 1'b1) saw_oe = 1'b1;
      if (sck_out === 1'b1 && prev_sck === 1'b0) begin
        rises++;
        if (rises == 1) first = i;
        last = i;
        seen = {seen[6:0], prev_sout};
      end
      prev_sck  = sck_out;
      prev_sout = sout_dmg;
      if (rises == 8) break;
    end
    total += 5;
    if (rises !== 8) begin bad++; $display("[TB] FAIL master rise count: got %0d want 8", rises); end
    if (last - first !== 56) begin bad++; $display("[TB] FAIL master period span: got %0d want 56", last - first); end
    if (!saw_oe || sck_oe !== 1'b0) begin bad++; $display("[TB] FAIL master sck_oe: seen_high=%b end=%b want 1/0", saw_oe, sck_oe); end
    if (seen !== 8'h81) begin bad++; $display("[TB] FAIL master sout bits: got %h want 81", seen); end
    wait_clk(2);
    if (rx_data !== 8'h00 || pulses - p0 !== 1) begin
      bad++; $display("[TB] FAIL master rx: got %h/%0d want 00/1", rx_data, pulses - p0);
    end
    master  = 1'b0;
    sin_dmg = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_timeout;
    logic [7:0] seen;
    int p0;
    p0 = pulses;
    dmg_bits(8'hE0, 3, seen);
    total += 4;
    if (busy !== 1'b1) begin bad++; $display("[TB] FAIL timeout busy mid: got %b want 1", busy); end
    wait_clk(TIMEOUT + 10);
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL timeout busy after: got %b want 0", busy); end
    if (pulses - p0 !== 0) begin bad++; $display("[TB] FAIL timeout rx_valid count: got %0d want 0", pulses - p0); end
    dmg_bits(8'h5A, 8, seen);
    if (rx_data !== 8'h5A || seen !== 8'hFF) begin
      bad++; $display("[TB] FAIL timeout recovery: rx=%h sout=%h want 5a/ff", rx_data, seen);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] seen;
    load_tx(8'hC3);
    dmg_bits(8'h00, 5, seen);
    load_tx(8'h3F);
    total += 2;
    if (tx_ready !== 1'b0) begin bad++; $display("[TB] FAIL rstmid tx_ready before: got %b want 0", tx_ready); end
    reset_n = 1'b0;
    #1;
    if (tx_ready !== 1'b1 || rx_data !== 8'h00 || rx_valid !== 1'b0 || busy !== 1'b0 ||
        sck_out !== 1'b1 || sck_oe !== 1'b0 || sout_dmg !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rstmid outputs: rdy=%b rx=%h v=%b busy=%b sck=%b oe=%b sout=%b want 1/00/0/0/1/0/1",
               tx_ready, rx_data, rx_valid, busy, sck_out, sck_oe, sout_dmg);
    end
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(3);
    dmg_bits(8'h77, 8, seen);
    total++;
    if (rx_data !== 8'h77 || seen !== 8'hFF) begin
      bad++; $display("[TB] FAIL rstmid next xfer: rx=%h sout=%h want 77/ff", rx_data, seen);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] seen1, seen2;
    logic mid_sout;
    int p0;
    p0 = pulses;
    load_tx(8'h11);
    fork
      load_tx(8'h22);
      begin
        dmg_bits(8'h00, 8, seen1);
        mid_sout = sout_dmg;
        dmg_bits(8'h00, 8, seen2);
      end
    join
    total += 5;
    if (seen1 !== 8'h11) begin bad++; $display("[TB] FAIL b2b first byte: got %h want 11", seen1); end
    if (mid_sout !== 1'b0) begin bad++; $display("[TB] FAIL b2b gap sout: got %b want 0", mid_sout); end
    if (seen2 !== 8'h22) begin bad++; $display("[TB] FAIL b2b second byte: got %h want 22", seen2); end
    if (pulses - p0 !== 2) begin bad++; $display("[TB] FAIL b2b rx_valid count: got %0d want 2", pulses - p0); end
    if (rx_data !== 8'h00) begin bad++; $display("[TB] FAIL b2b rx_data: got %h want 00", rx_data); end
  endtask

  initial begin
    test_reset();
    test_slave();
    test_slave_empty();
    test_master();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
